// File: rtl/flash_read_arbiter.sv
// Two-requester arbiter for the single flash read port; one single-beat read outstanding.
// Grant -> flash_mem_read next cycle; data returned one cycle after flash valid; backpressure via waitrequest.
module flash_read_arbiter #(
  parameter int ADDR_W       = 23,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              CLK_50M,
  input  logic              reset,
  input  logic              rq0_read,
  input  logic [ADDR_W-1:0] rq0_address,
  output logic              rq0_waitrequest,
  output logic [DATA_W-1:0] rq0_readdata,
  output logic              rq0_readdatavalid,
  input  logic              rq1_read,
  input  logic [ADDR_W-1:0] rq1_address,
  output logic              rq1_waitrequest,
  output logic [DATA_W-1:0] rq1_readdata,
  output logic              rq1_readdatavalid,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  input  logic              flash_mem_waitrequest,
  input  logic [DATA_W-1:0] flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;

  localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

  state_t            state;
  logic              gnt;
  logic [7:0]        starve_cnt;
  logic [15:0]       to_cnt;
  logic              accept;
  logic              pick1;
  logic              done;
  logic [DATA_W-1:0] ret_dat;

  assign accept          = (state == ISSUE) && !flash_mem_waitrequest;
  assign rq0_waitrequest = !(accept && !gnt);
  assign rq1_waitrequest = !(accept && gnt);
  assign busy            = (state != IDLE);

  // Requester 1 wins only when alone or when it has waited STARVE_LIMIT grants.
  assign pick1   = rq1_read && (!rq0_read || (starve_cnt == STARVE_MAX));
  // A timeout completes the read with zero data so the requester never hangs.
  assign done    = (state == WAIT_DATA) && (flash_mem_readdatavalid || (to_cnt == TO_LAST));
  assign ret_dat = flash_mem_readdatavalid ? flash_mem_readdata : '0;

  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      gnt               <= 1'b0;
      starve_cnt        <= '0;
      to_cnt            <= '0;
      flash_mem_read    <= 1'b0;
      flash_mem_address <= '0;
      rq0_readdata      <= '0;
      rq1_readdata      <= '0;
      rq0_readdatavalid <= 1'b0;
      rq1_readdatavalid <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      rq0_readdatavalid <= 1'b0;
      rq1_readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          if (rq0_read || rq1_read) begin
            gnt               <= pick1;
            flash_mem_address <= pick1 ? rq1_address : rq0_address;
            flash_mem_read    <= 1'b1;
            state             <= ISSUE;
            if (pick1)
              starve_cnt <= '0;
            else if (rq1_read && (starve_cnt != STARVE_MAX))
              starve_cnt <= starve_cnt + 8'd1;
          end
        end
        ISSUE: begin
          if (!flash_mem_waitrequest) begin
            flash_mem_read <= 1'b0;
            to_cnt         <= '0;
            state          <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (done) begin
            state <= IDLE;
            if (!flash_mem_readdatavalid)
              timeout_err <= 1'b1;
            if (gnt) begin
              rq1_readdata      <= ret_dat;
              rq1_readdatavalid <= 1'b1;
            end else begin
              rq0_readdata      <= ret_dat;
              rq0_readdatavalid <= 1'b1;
            end
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
